// File: rtl/fpu_pkg.sv
// Shared FPU types and constants: rounding modes, binary32 field widths and
// the state encoding of the sequential integer-to-float converter.
package fpu_pkg;

  typedef enum logic [2:0] {
    RM_RNE = 3'b000,
    RM_RTZ = 3'b001,
    RM_RDN = 3'b010,
    RM_RUP = 3'b011,
    RM_RMM = 3'b100
  } rm_e;

  localparam int EXP_BIAS = 127;
  localparam int EXP_W    = 8;
  localparam int MANT_W   = 23;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_NORM  = 2'b01,
    ST_ROUND = 2'b10,
    ST_DONE  = 2'b11
  } cvt_state_e;

  // Reserved encodings 101..111 behave as round-to-nearest-even.
  function automatic rm_e decode_rm(input logic [2:0] raw);
    if (raw > 3'b100) begin
      decode_rm = RM_RNE;
    end else begin
      decode_rm = rm_e'(raw);
    end
  endfunction

endpackage

// File: rtl/fp_round_decide.sv
// Rounding decision: from sign, lsb, guard and sticky bits and a rounding
// mode, decide whether to increment the truncated mantissa and whether the
// result is inexact. Purely combinational so any rounder can share it.
module fp_round_decide
  import fpu_pkg::*;
(
  input  logic sign,
  input  logic lsb,
  input  logic guard,
  input  logic sticky,
  input  rm_e  rm,
  output logic round_up,
  output logic nx
);

  // Select the increment rule for the active rounding mode.
  always_comb begin
    round_up = 1'b0;
    case (rm)
      RM_RNE:  round_up = guard & (sticky | lsb);
      RM_RTZ:  round_up = 1'b0;
      RM_RDN:  round_up = sign & (guard | sticky);
      RM_RUP:  round_up = ~sign & (guard | sticky);
      RM_RMM:  round_up = guard;
      default: round_up = guard & (sticky | lsb);
    endcase
  end

  assign nx = guard | sticky;

endmodule

// File: rtl/fcvt_s_w_seq.sv
// Sequential FCVT.S.W / FCVT.S.WU: takes a signed or unsigned 32-bit integer,
// normalizes its magnitude one bit per cycle, rounds once and presents a
// packed binary32 result with an inexact flag behind a valid/ready handshake.
module fcvt_s_w_seq
  import fpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_int,
  input  logic        in_signed,
  input  logic [2:0]  in_rm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_num,
  output logic        out_nx
);

  cvt_state_e        state_q;
  logic              sign_q;
  logic [31:0]       mag_q;
  rm_e               rm_q;
  logic [4:0]        count_q;
  logic [31:0]       out_num_q;
  logic              out_nx_q;

  logic              in_neg;
  logic [31:0]       in_mag;
  logic              rnd_lsb;
  logic              rnd_guard;
  logic              rnd_sticky;
  logic              rnd_up;
  logic              rnd_nx;
  logic [EXP_W-1:0]  exp_base;
  logic [MANT_W:0]   mant_sum;
  logic [MANT_W-1:0] mant_fin;
  logic [EXP_W-1:0]  exp_fin;

  // Magnitude of the incoming operand; the most negative value maps to 0x80000000.
  always_comb begin
    in_neg = in_signed & in_int[31];
    in_mag = in_neg ? (~in_int + 32'd1) : in_int;
  end

  // Field extraction and mantissa increment for the normalized magnitude.
  always_comb begin
    rnd_lsb    = mag_q[8];
    rnd_guard  = mag_q[7];
    rnd_sticky = |mag_q[6:0];
    exp_base   = EXP_W'(EXP_BIAS + 31) - {3'b000, count_q};
    mant_sum   = {1'b0, mag_q[30:8]} + {{MANT_W{1'b0}}, rnd_up};
    mant_fin   = mant_sum[MANT_W] ? '0 : mant_sum[MANT_W-1:0];
    exp_fin    = exp_base + {{(EXP_W-1){1'b0}}, mant_sum[MANT_W]};
  end

  fp_round_decide u_round_decide (
    .sign     (sign_q),
    .lsb      (rnd_lsb),
    .guard    (rnd_guard),
    .sticky   (rnd_sticky),
    .rm       (rm_q),
    .round_up (rnd_up),
    .nx       (rnd_nx)
  );

  // Converter FSM: accept, shift-normalize, round, then hold until taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      sign_q    <= 1'b0;
      mag_q     <= '0;
      rm_q      <= RM_RNE;
      count_q   <= '0;
      out_num_q <= '0;
      out_nx_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            sign_q  <= in_neg;
            mag_q   <= in_mag;
            rm_q    <= decode_rm(in_rm);
            count_q <= '0;
            if (in_mag == 32'd0) begin
              out_num_q <= '0;
              out_nx_q  <= 1'b0;
              state_q   <= ST_DONE;
            end else begin
              state_q <= ST_NORM;
            end
          end
        end
        ST_NORM: begin
          if (!mag_q[31]) begin
            mag_q   <= {mag_q[30:0], 1'b0};
            count_q <= count_q + 5'd1;
          end else begin
            state_q <= ST_ROUND;
          end
        end
        ST_ROUND: begin
          out_num_q <= {sign_q, exp_fin, mant_fin};
          out_nx_q  <= rnd_nx;
          state_q   <= ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign out_num   = out_num_q;
  assign out_nx    = out_nx_q;

endmodule

// File: doc/fcvt_s_w_seq.md
Name: fcvt_s_w_seq

Overview:
- Multi-cycle integer-to-binary32 converter, implementing RISC-V FCVT.S.W and FCVT.S.WU.
- Sits beside fadd_total in the FPU datapath and is the reverse direction of its float-to-integer-granularity rounding path.
- Takes a 32-bit signed or unsigned integer plus a rounding mode and returns a rounded, packed single-precision result with inexact flag.
- Uses a valid/ready handshake on input and output; normalization is iterative, one bit per cycle.

Parameters:
- None. Widths are fixed: 32-bit integer in, binary32 out, bias 127.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous and active-high
- in_valid  in  1  request valid
- in_ready  out  1  converter idle and able to accept
- in_int  in  32  integer operand
- in_signed  in  1  1 = treat in_int as two's complement (W); 0 = unsigned (WU)
- in_rm  in  3  rounding mode: 000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM; 101-111 treated as RNE
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_num  out  32  packed binary32 result
- out_nx  out  1  inexact flag for this result

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst, and dominates every other input. On reset: state IDLE, in_ready=1, out_valid=0, out_num=0, out_nx=0, internal registers cleared. Reset mid-operation discards the operation in progress without producing output.
- States: IDLE, NORM, ROUND, DONE. in_ready = (state==IDLE); out_valid = (state==DONE); both are registered-state decodes.
- IDLE:
  - Accept on in_valid && in_ready, in cycle 0.
  - Latch sign = in_signed & in_int[31], mag = |in_int| as 32-bit unsigned (-2^31 gives 0x80000000), rm, shift count = 0.
  - mag==0: out_num = {sign=0, all zeros}, out_nx=0, next state DONE. Result is +0.0 always.
  - Otherwise: next state NORM.
- NORM:
  - If mag[31]==0: mag <<= 1, count += 1, stay in NORM.
  - Else: go to ROUND.
  - Occupies lz+1 cycles, where lz = leading zeros of mag (0..31).
- ROUND (single cycle):
  - Exponent = 158 - count, 8 bits.
  - Fields: mant = mag[30:8], lsb = mag[8], guard = mag[7], sticky = |mag[6:0].
  - Round-up condition: RNE guard&(sticky|lsb); RTZ 0; RDN sign&(guard|sticky); RUP ~sign&(guard|sticky); RMM guard.
  - If round-up, mant += 1. Carry out of mant zeroes mant and increments exponent (max 159; overflow impossible).
  - out_nx = guard|sticky. Register out_num = {sign, exp, mant}, then go to DONE.
- DONE:
  - out_num and out_nx are held stable while out_valid && !out_ready.
  - On out_ready, next state IDLE. No same-cycle re-accept: in_ready rises the cycle after handoff.
- Latency, accept edge to out_valid:
  - Nonzero operand: lz+3 cycles (3..34).
  - Zero operand: 1 cycle.
- Throughput is one operation in flight. in_* are ignored when in_ready=0, and out_ready is ignored outside DONE.
- No $display or other simulation-only constructs. Every combinational signal is assigned on all paths, so there are no latches.

Decomposition:
- fpu_pkg holds:
  - rm_e enum (RNE, RTZ, RDN, RUP, RMM)
  - localparams EXP_BIAS=127, EXP_W=8, MANT_W=23
  - cvt_state_e enum
- Sub-module fp_round_decide: purely combinational, taking sign, lsb, guard, sticky, rm and returning round_up and nx. It is reusable by fadd_total's rounder later.

Test Plan:
- signed 0x00000001, RNE → out_num 0x3F800000, nx 0, out_valid 34 cycles after accept.
- signed 0x80000000, RNE → 0xCF000000, nx 0, latency 3; signed 0xFFFFFFFF → 0xBF800000.
- unsigned 0xFFFFFFFF:
  - RNE → 0x4F800000, nx 1 (mantissa carry bumps exponent).
  - RTZ → 0x4F7FFFFF, nx 1.
  - RDN (sign 0) → 0x4F7FFFFF.
- signed 0x01000001:
  - RNE → 0x4B800000 (tie to even).
  - RMM → 0x4B800001.
  - RUP → 0x4B800001.
  - All three give nx 1.
- 0x00000000 with any rm → 0x00000000, nx 0, latency 1; 0x00000003 then holds out_ready=0 for 5 cycles → out_num 0x40400000 stable, in_ready 0 throughout, IDLE one cycle after out_ready.
- Assert rst during NORM of operand 0x00000001 → next cycle state IDLE, out_valid 0, out_num 0; a fresh request then completes normally.
